front_rat: RTL and testbench

//  Speculative (front-end) register alias table for the rename stage. Maps arch regs to phys

---
 rtl/front_rat.sv | 100 ++++++++++
 tb/tb_front_rat.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/front_rat.sv
// Speculative rename-stage register alias table.
// Restores from the committed map on flush, then holds rename off for a recovery window.
module front_rat #(
    parameter int ARCH_REGS   = 32,
    parameter int PHY_WIDTH   = 6,
    parameter int RECOVER_LAT = 1,
    localparam int AW = $clog2(ARCH_REGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           stall,
    input  logic [PHY_WIDTH*ARCH_REGS-1:0] back_rat,
    input  logic                           rename_valid,
    input  logic [AW-1:0]                  rs1_arch,
    input  logic [AW-1:0]                  rs2_arch,
    input  logic [AW-1:0]                  rd_arch,
    input  logic [PHY_WIDTH-1:0]           rd_phy_new,
    output logic [PHY_WIDTH-1:0]           rs1_phy,
    output logic [PHY_WIDTH-1:0]           rs2_phy,
    output logic [PHY_WIDTH-1:0]           rd_phy_old,
    output logic                           rename_ready
);

    localparam int CW = (RECOVER_LAT > 1) ? $clog2(RECOVER_LAT) : 1;

    typedef enum logic {
        RUN,
        RECOVER
    } state_t;

    state_t              state, state_nx;
    logic [CW-1:0]       cnt, cnt_nx;
    logic                restore;
    logic                wr_en;
    logic [PHY_WIDTH-1:0] frat [ARCH_REGS];

    // Slice 0 of the committed map is never loaded: x0 is hardwired.
    logic unused_slice0;
    assign unused_slice0 = ^back_rat[PHY_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        restore      = 1'b0;
        wr_en        = 1'b0;
        rename_ready = 1'b0;
        unique case (state)
            RUN: begin
                rename_ready = 1'b1;
                if (flush) begin
                    restore  = 1'b1;
                    cnt_nx   = CW'(RECOVER_LAT - 1);
                    state_nx = RECOVER;
                end else begin
                    wr_en = rename_valid & ~stall & (rd_arch != '0);
                end
            end
            RECOVER: begin
                if (flush) begin
                    restore = 1'b1;
                    cnt_nx  = CW'(RECOVER_LAT - 1);
                end else if (cnt == '0) begin
                    state_nx = RUN;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++)
                frat[i] <= PHY_WIDTH'(i);
        end else if (restore) begin
            frat[0] <= '0;
            for (int i = 1; i < ARCH_REGS; i++)
                frat[i] <= back_rat[i*PHY_WIDTH +: PHY_WIDTH];
        end else if (wr_en) begin
            frat[rd_arch] <= rd_phy_new;
        end
    end

    assign rs1_phy    = frat[rs1_arch];
    assign rs2_phy    = frat[rs2_arch];
    assign rd_phy_old = frat[rd_arch];

endmodule

// File: tb/tb_front_rat.sv
// Bench for front_rat: two instances (recovery latency 1 and 3) on shared stimulus,
// checked against a per-instance array model with a remaining-blocked-cycles count.
module tb_front_rat;

    localparam int AR = 32;
    localparam int PW = 6;

    logic            clk = 1'b0;
    logic            rst, flush, stall, rename_valid;
    logic [PW*AR-1:0] back_rat;
    logic [4:0]      rs1_arch, rs2_arch, rd_arch;
    logic [PW-1:0]   rd_phy_new;
    logic [PW-1:0]   rs1_a, rs2_a, old_a, rs1_b, rs2_b, old_b;
    logic            rdy_a, rdy_b;

    front_rat #(.ARCH_REGS(AR), .PHY_WIDTH(PW), .RECOVER_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .back_rat(back_rat), .rename_valid(rename_valid),
        .rs1_arch(rs1_arch), .rs2_arch(rs2_arch), .rd_arch(rd_arch),
        .rd_phy_new(rd_phy_new), .rs1_phy(rs1_a), .rs2_phy(rs2_a),
        .rd_phy_old(old_a), .rename_ready(rdy_a)
    );

    front_rat #(.ARCH_REGS(AR), .PHY_WIDTH(PW), .RECOVER_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .back_rat(back_rat), .rename_valid(rename_valid),
        .rs1_arch(rs1_arch), .rs2_arch(rs2_arch), .rd_arch(rd_arch),
        .rd_phy_new(rd_phy_new), .rs1_phy(rs1_b), .rs2_phy(rs2_b),
        .rd_phy_old(old_b), .rename_ready(rdy_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [PW-1:0] m [2][AR];
    int rem [2];
    int lat [2] = '{1, 3};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_rs1", 32'(rs1_a), 32'(m[0][rs1_arch]));
        chk("a_rs2", 32'(rs2_a), 32'(m[0][rs2_arch]));
        chk("a_old", 32'(old_a), 32'(m[0][rd_arch]));
        chk("a_rdy", 32'(rdy_a), 32'(rem[0] == 0));
        chk("b_rs1", 32'(rs1_b), 32'(m[1][rs1_arch]));
        chk("b_rs2", 32'(rs2_b), 32'(m[1][rs2_arch]));
        chk("b_old", 32'(old_b), 32'(m[1][rd_arch]));
        chk("b_rdy", 32'(rdy_b), 32'(rem[1] == 0));
    endtask

    // Reference: rem = cycles rename stays blocked; writes only when unblocked.
    task automatic model();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int i = 0; i < AR; i++) m[k][i] = PW'(i);
                rem[k] = 0;
            end else if (flush) begin
                m[k][0] = '0;
                for (int i = 1; i < AR; i++) m[k][i] = back_rat[i*PW +: PW];
                rem[k] = lat[k];
            end else if (rem[k] > 0) begin
                rem[k] = rem[k] - 1;
            end else if (rename_valid && !stall && rd_arch != 0) begin
                m[k][rd_arch] = rd_phy_new;
            end
        end
    endtask

    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        model();
        #1;
    endtask

    task automatic rand_back();
        for (int i = 0; i < AR; i++) back_rat[i*PW +: PW] = PW'($urandom);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0; rename_valid = 1'b0;
        back_rat = '0; rs1_arch = '0; rs2_arch = '0; rd_arch = '0;
        rd_phy_new = '0;
        @(posedge clk);
        model();
        #1;
        rst = 1'b0;

        // reset map
        rs1_arch = 5'd5; rd_arch = 5'd31;
        #1;
        chk("t1_rs1", 32'(rs1_a), 32'd5);
        chk("t1_old", 32'(old_a), 32'd31);
        chk("t1_rdy", 32'(rdy_a), 32'd1);
        step();

        // rename, back-to-back same rd
        rd_arch = 5'd3; rd_phy_new = 6'd40; rename_valid = 1'b1;
        #1;
        chk("t2_old0", 32'(old_a), 32'd3);
        step();
        rd_phy_new = 6'd41; rs1_arch = 5'd3;
        #1;
        chk("t2_rs1", 32'(rs1_a), 32'd40);
        chk("t2_old1", 32'(old_b), 32'd40);
        step();

        // x0 and stall
        rd_arch = 5'd0; rd_phy_new = 6'd50;
        step();
        rd_arch = 5'd7; rd_phy_new = 6'd45; stall = 1'b1;
        step();
        stall = 1'b0; rename_valid = 1'b0; rs1_arch = 5'd7; rs2_arch = 5'd0;
        #1;
        chk("t3_rs1", 32'(rs1_a), 32'd7);
        chk("t3_x0", 32'(rs2_b), 32'd0);
        step();

        // flush restore
        rand_back();
        back_rat[3*PW +: PW] = 6'd33;
        back_rat[0 +: PW] = 6'd9;
        flush = 1'b1;
        step();
        flush = 1'b0; rs1_arch = 5'd3; rs2_arch = 5'd0;
        #1;
        chk("t4_rdy", 32'(rdy_a), 32'd0);
        chk("t4_rs1", 32'(rs1_a), 32'd33);
        chk("t4_x0", 32'(rs2_a), 32'd0);
        for (int i = 0; i < 4; i++) step();

        // flush colliding with rename, then re-flush during recovery
        rand_back();
        flush = 1'b1; rename_valid = 1'b1; rd_arch = 5'd4; rd_phy_new = 6'd60;
        step();
        flush = 1'b0; rename_valid = 1'b0; rs1_arch = 5'd4;
        #1;
        chk("t5_rs1", 32'(rs1_a), 32'(back_rat[4*PW +: PW]));
        step();
        rand_back();
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // reset in the middle of recovery
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; rs1_arch = 5'd9;
        #1;
        chk("t6_rdy", 32'(rdy_b), 32'd1);
        chk("t6_rs1", 32'(rs1_b), 32'd9);
        step();

        // random traffic
        for (int n = 0; n < 500; n++) begin
            rst          = ($urandom_range(0, 59) == 0);
            flush        = ($urandom_range(0, 9) == 0);
            stall        = ($urandom_range(0, 3) == 0);
            rename_valid = ($urandom_range(0, 3) != 0);
            rs1_arch     = 5'($urandom);
            rs2_arch     = 5'($urandom);
            rd_arch      = 5'($urandom);
            rd_phy_new   = PW'($urandom);
            if ($urandom_range(0, 3) == 0) rand_back();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
